// File: rtl/mesh_wh_packetizer.sv
// Purpose: wraps a message request (dst row/col, length) and its payload words into one wormhole packet (HEAD, BODY..., TAIL).
// Latency: each flit is valid on ochan one cycle after its msg/pld handshake; sustains 1 flit/cycle while ochan_rdy_i=1.
// Backpressure: single output register; msg_rdy_o/pld_rdy_o drop combinationally whenever a valid flit is stalled.
//
// Ports:
//   clk_i, rst_ni                                  clock, async active-low reset
//   msg_vld_i/msg_rdy_o, msg_dst_row_i/_col_i, msg_len_i   message request channel
//   pld_data_i, pld_vld_i/pld_rdy_o                payload word channel
//   ochan_data_o, ochan_vld_o/ochan_rdy_i          flit output to the node's resource input
//   err_o                                          1-cycle pulse: request dropped for out-of-mesh address
//   pckt_cnt_o                                     wrapping count of tails taken by the NoC
module mesh_wh_packetizer #(
  parameter int ROW_N     = 3,
  parameter int COL_M     = 3,
  parameter int FLIT_ID_W = 2,
  parameter int CHANNEL_W = 10,
  parameter int LEN_W     = 4,
  localparam int ROW_W    = (ROW_N > 1) ? $clog2(ROW_N) : 1,
  localparam int COL_W    = (COL_M > 1) ? $clog2(COL_M) : 1,
  localparam int DATA_W   = CHANNEL_W - FLIT_ID_W
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 msg_vld_i,
  output logic                 msg_rdy_o,
  input  logic [ROW_W-1:0]     msg_dst_row_i,
  input  logic [COL_W-1:0]     msg_dst_col_i,
  input  logic [LEN_W-1:0]     msg_len_i,
  input  logic [DATA_W-1:0]    pld_data_i,
  input  logic                 pld_vld_i,
  output logic                 pld_rdy_o,
  output logic [CHANNEL_W-1:0] ochan_data_o,
  output logic                 ochan_vld_o,
  input  logic                 ochan_rdy_i,
  output logic                 err_o,
  output logic [15:0]          pckt_cnt_o
);

  localparam logic [FLIT_ID_W-1:0] ID_HEAD = FLIT_ID_W'(1);
  localparam logic [FLIT_ID_W-1:0] ID_BODY = FLIT_ID_W'(2);
  localparam logic [FLIT_ID_W-1:0] ID_TAIL = FLIT_ID_W'(3);

  // One extra bit so ROW_N/COL_M equal to 2^W still compare correctly.
  localparam logic [ROW_W:0] ROW_LIM = ROW_N[ROW_W:0];
  localparam logic [COL_W:0] COL_LIM = COL_M[COL_W:0];

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PAYLOAD = 2'd1,
    S_ZTAIL   = 2'd2
  } state_t;

  state_t               state;
  logic [LEN_W-1:0]     rem;

  logic                 slot_free;
  logic                 msg_hs;
  logic                 pld_hs;
  logic                 addr_ok;
  logic                 last_pld;
  logic                 load;
  logic [CHANNEL_W-1:0] load_dat;
  logic [DATA_W-1:0]    head_dat;

  // The output register can take a new flit when it is empty or being drained this cycle.
  assign slot_free = !ochan_vld_o || ochan_rdy_i;
  assign msg_rdy_o = (state == S_IDLE) && slot_free;
  assign pld_rdy_o = (state == S_PAYLOAD) && slot_free;

  assign msg_hs   = msg_vld_i && msg_rdy_o;
  assign pld_hs   = pld_vld_i && pld_rdy_o;
  assign addr_ok  = ({1'b0, msg_dst_row_i} < ROW_LIM) && ({1'b0, msg_dst_col_i} < COL_LIM);
  assign last_pld = (rem == LEN_W'(1));

  always_comb begin
    head_dat                  = '0;
    head_dat[COL_W-1:0]       = msg_dst_col_i;
    head_dat[COL_W +: ROW_W]  = msg_dst_row_i;
  end

  // Next flit to place in the output register, if any.
  always_comb begin
    load     = 1'b0;
    load_dat = '0;
    case (state)
      S_IDLE: begin
        if (msg_hs && addr_ok) begin
          load     = 1'b1;
          load_dat = {ID_HEAD, head_dat};
        end
      end
      S_PAYLOAD: begin
        if (pld_hs) begin
          load     = 1'b1;
          load_dat = {(last_pld ? ID_TAIL : ID_BODY), pld_data_i};
        end
      end
      S_ZTAIL: begin
        // Zero-length message: close the packet with an empty tail.
        if (slot_free) begin
          load     = 1'b1;
          load_dat = {ID_TAIL, DATA_W'(0)};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= S_IDLE;
      rem          <= '0;
      ochan_vld_o  <= 1'b0;
      ochan_data_o <= '0;
      err_o        <= 1'b0;
      pckt_cnt_o   <= '0;
    end else begin
      err_o <= msg_hs && !addr_ok;

      if (ochan_vld_o && ochan_rdy_i && (ochan_data_o[CHANNEL_W-1 -: FLIT_ID_W] == ID_TAIL))
        pckt_cnt_o <= pckt_cnt_o + 16'd1;

      // A load in the drain cycle keeps vld high; data only changes on a load, so it is frozen while stalled.
      if (load) begin
        ochan_data_o <= load_dat;
        ochan_vld_o  <= 1'b1;
      end else if (ochan_rdy_i) begin
        ochan_vld_o  <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (msg_hs && addr_ok) begin
            rem   <= msg_len_i;
            state <= (msg_len_i != '0) ? S_PAYLOAD : S_ZTAIL;
          end
        end
        S_PAYLOAD: begin
          if (pld_hs) begin
            rem <= rem - LEN_W'(1);
            if (last_pld) state <= S_IDLE;
          end
        end
        S_ZTAIL: begin
          if (slot_free) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mesh_wh_packetizer.sv
module tb_mesh_wh_packetizer;

  localparam int NMSG   = 60;
  localparam int BUDGET = 20000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       msg_vld, msg_rdy;
  logic [1:0] msg_row, msg_col;
  logic [3:0] msg_len;
  logic [7:0] pld_data;
  logic       pld_vld, pld_rdy;
  logic [9:0] och_data;
  logic       och_vld, och_rdy;
  logic       err;
  logic [15:0] pckt_cnt;

  always #5 clk = ~clk;

  mesh_wh_packetizer #(
    .ROW_N(3), .COL_M(3), .FLIT_ID_W(2), .CHANNEL_W(10), .LEN_W(4)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .msg_vld_i(msg_vld), .msg_rdy_o(msg_rdy),
    .msg_dst_row_i(msg_row), .msg_dst_col_i(msg_col), .msg_len_i(msg_len),
    .pld_data_i(pld_data), .pld_vld_i(pld_vld), .pld_rdy_o(pld_rdy),
    .ochan_data_o(och_data), .ochan_vld_o(och_vld), .ochan_rdy_i(och_rdy),
    .err_o(err), .pckt_cnt_o(pckt_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    msg_vld  = 1'b0;
    msg_row  = '0;
    msg_col  = '0;
    msg_len  = '0;
    pld_vld  = 1'b0;
    pld_data = '0;
  endtask

  task automatic set_msg(input logic [1:0] r, input logic [1:0] c, input logic [3:0] l);
    msg_vld = 1'b1;
    msg_row = r;
    msg_col = c;
    msg_len = l;
  endtask

  // {vld, data} as seen on ochan
  function automatic logic [31:0] och();
    return 32'({och_vld, och_data});
  endfunction

  logic [9:0] b2b [4] = '{10'h100, 10'h311, 10'h106, 10'h322};

  logic [9:0] expq [$];
  logic [7:0] pldq [$];
  int mrow [NMSG];
  int mcol [NMSG];
  int mlen [NMSG];

  initial begin
    int nbad, ngood, mi, pi, ei, cyc, tails, err_seen;
    logic exp_err, prev_stall;
    logic [9:0] prev_dat;
    logic [7:0] d;

    idle_inputs();
    och_rdy = 1'b1;

    // ---- reset state ----
    @(negedge clk);
    check("rst_vld", 32'(och_vld), 0);
    check("rst_data", 32'(och_data), 0);
    check("rst_err", 32'(err), 0);
    check("rst_cnt", 32'(pckt_cnt), 0);
    check("rst_msg_rdy", 32'(msg_rdy), 1);
    check("rst_pld_rdy", 32'(pld_rdy), 0);
    rst_n = 1'b1;
    next_cycle();

    // ---- basic packet (2,1) len 2 ----
    set_msg(2'd2, 2'd1, 4'd2);
    @(negedge clk);
    check("d1_msg_rdy", 32'(msg_rdy), 1);
    next_cycle();
    msg_vld = 1'b0; pld_vld = 1'b1; pld_data = 8'hA5;
    @(negedge clk);
    check("d1_head", och(), 32'({1'b1, 10'h109}));
    check("d1_pld_rdy", 32'(pld_rdy), 1);
    next_cycle();
    pld_data = 8'h3C;
    @(negedge clk);
    check("d1_body", och(), 32'({1'b1, 10'h2A5}));
    next_cycle();
    pld_vld = 1'b0;
    @(negedge clk);
    check("d1_tail", och(), 32'({1'b1, 10'h33C}));
    next_cycle();
    @(negedge clk);
    check("d1_idle_vld", 32'(och_vld), 0);
    check("d1_cnt", 32'(pckt_cnt), 1);
    next_cycle();

    // ---- zero-length packet to (0,2) ----
    set_msg(2'd0, 2'd2, 4'd0);
    pld_vld = 1'b1; pld_data = 8'hEE;
    @(negedge clk);
    check("d2_pld_rdy0", 32'(pld_rdy), 0);
    next_cycle();
    msg_vld = 1'b0;
    @(negedge clk);
    check("d2_head", och(), 32'({1'b1, 10'h102}));
    check("d2_pld_rdy1", 32'(pld_rdy), 0);
    next_cycle();
    @(negedge clk);
    check("d2_ztail", och(), 32'({1'b1, 10'h300}));
    check("d2_pld_rdy2", 32'(pld_rdy), 0);
    next_cycle();
    pld_vld = 1'b0;
    @(negedge clk);
    check("d2_cnt", 32'(pckt_cnt), 2);
    next_cycle();

    // ---- out-of-range row ----
    set_msg(2'd3, 2'd0, 4'd1);
    @(negedge clk);
    check("d3_err_pre", 32'(err), 0);
    next_cycle();
    msg_vld = 1'b0;
    @(negedge clk);
    check("d3_err", 32'(err), 1);
    check("d3_vld", 32'(och_vld), 0);
    next_cycle();
    @(negedge clk);
    check("d3_err_off", 32'(err), 0);
    check("d3_vld2", 32'(och_vld), 0);
    check("d3_msg_rdy", 32'(msg_rdy), 1);
    check("d3_cnt", 32'(pckt_cnt), 2);
    next_cycle();

    // ---- 5-cycle stall mid-packet ----
    set_msg(2'd2, 2'd2, 4'd2);
    @(negedge clk);
    next_cycle();
    msg_vld = 1'b0; pld_vld = 1'b1; pld_data = 8'h77;
    @(negedge clk);
    check("d4_head", och(), 32'({1'b1, 10'h10A}));
    next_cycle();
    pld_data = 8'h88; och_rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("d4_frozen", och(), 32'({1'b1, 10'h277}));
      check("d4_pld_rdy", 32'(pld_rdy), 0);
      check("d4_msg_rdy", 32'(msg_rdy), 0);
      next_cycle();
    end
    och_rdy = 1'b1;
    @(negedge clk);
    check("d4_release", och(), 32'({1'b1, 10'h277}));
    check("d4_pld_rdy_rel", 32'(pld_rdy), 1);
    next_cycle();
    pld_vld = 1'b0;
    @(negedge clk);
    check("d4_tail", och(), 32'({1'b1, 10'h388}));
    next_cycle();
    @(negedge clk);
    check("d4_vld", 32'(och_vld), 0);
    check("d4_cnt", 32'(pckt_cnt), 3);
    next_cycle();

    // ---- two len-1 packets back to back ----
    set_msg(2'd0, 2'd0, 4'd1);
    @(negedge clk);
    next_cycle();
    set_msg(2'd1, 2'd2, 4'd1);
    pld_vld = 1'b1; pld_data = 8'h11;
    @(negedge clk);
    check("b2b_f0", och(), 32'({1'b1, b2b[0]}));
    next_cycle();
    pld_vld = 1'b0;
    @(negedge clk);
    check("b2b_f1", och(), 32'({1'b1, b2b[1]}));
    check("b2b_msg_rdy_tail", 32'(msg_rdy), 1);
    next_cycle();
    msg_vld = 1'b0; pld_vld = 1'b1; pld_data = 8'h22;
    @(negedge clk);
    check("b2b_f2", och(), 32'({1'b1, b2b[2]}));
    next_cycle();
    pld_vld = 1'b0;
    @(negedge clk);
    check("b2b_f3", och(), 32'({1'b1, b2b[3]}));
    next_cycle();
    @(negedge clk);
    check("b2b_cnt", 32'(pckt_cnt), 5);
    next_cycle();

    // ---- async reset mid-BODY ----
    set_msg(2'd1, 2'd1, 4'd3);
    @(negedge clk);
    next_cycle();
    msg_vld = 1'b0; pld_vld = 1'b1; pld_data = 8'h01;
    @(negedge clk);
    next_cycle();
    pld_vld = 1'b0;
    @(negedge clk);
    check("rst2_body", och(), 32'({1'b1, 10'h201}));
    #2 rst_n = 1'b0;
    #1;
    check("rst2_vld", 32'(och_vld), 0);
    check("rst2_cnt", 32'(pckt_cnt), 0);
    check("rst2_msg_rdy", 32'(msg_rdy), 1);
    check("rst2_pld_rdy", 32'(pld_rdy), 0);
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    set_msg(2'd2, 2'd2, 4'd1);
    @(negedge clk);
    next_cycle();
    msg_vld = 1'b0; pld_vld = 1'b1; pld_data = 8'h5A;
    @(negedge clk);
    check("rst2_head", och(), 32'({1'b1, 10'h10A}));
    next_cycle();
    pld_vld = 1'b0;
    @(negedge clk);
    check("rst2_tail", och(), 32'({1'b1, 10'h35A}));
    next_cycle();
    @(negedge clk);
    check("rst2_cnt_after", 32'(pckt_cnt), 1);
    next_cycle();

    // ---- randomized traffic against a packet-level model ----
    nbad = 0; ngood = 0;
    for (int i = 0; i < NMSG; i++) begin
      mrow[i] = $urandom_range(0, 3);
      mcol[i] = $urandom_range(0, 3);
      mlen[i] = ($urandom_range(0, 7) == 0) ? 15 : $urandom_range(0, 4);
      if (mrow[i] < 3 && mcol[i] < 3) begin
        ngood++;
        expq.push_back({2'b01, 4'b0000, 2'(mrow[i]), 2'(mcol[i])});
        if (mlen[i] == 0) expq.push_back(10'h300);
        for (int k = 0; k < mlen[i]; k++) begin
          d = 8'($urandom);
          pldq.push_back(d);
          expq.push_back({((k == mlen[i] - 1) ? 2'b11 : 2'b10), d});
        end
      end else begin
        nbad++;
      end
    end

    mi = 0; pi = 0; ei = 0; cyc = 0; tails = 0; err_seen = 0;
    exp_err = 1'b0; prev_stall = 1'b0; prev_dat = '0;
    while ((mi < NMSG || pi < pldq.size() || ei < expq.size()) && cyc < BUDGET) begin
      cyc++;
      msg_vld = (mi < NMSG) && ($urandom_range(0, 3) != 0);
      if (mi < NMSG) begin
        msg_row = 2'(mrow[mi]); msg_col = 2'(mcol[mi]); msg_len = 4'(mlen[mi]);
      end
      pld_vld  = (pi < pldq.size()) && ($urandom_range(0, 3) != 0);
      pld_data = (pi < pldq.size()) ? pldq[pi] : 8'($urandom);
      och_rdy  = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      check("rnd_err", 32'(err), 32'(exp_err));
      if (err) err_seen++;
      check("rnd_cnt", 32'(pckt_cnt), 32'(1 + tails));
      if (prev_stall) check("rnd_hold", och(), 32'({1'b1, prev_dat}));
      if (och_vld && !och_rdy) check("rnd_bp_rdy", 32'({msg_rdy, pld_rdy}), 0);
      if (och_vld && och_rdy) begin
        if (ei < expq.size()) begin
          check("rnd_flit", 32'(och_data), 32'(expq[ei]));
          if (expq[ei][9:8] == 2'b11) tails++;
          ei++;
        end else begin
          check("rnd_extra_flit", 32'(och_vld), 0);
        end
      end
      exp_err = msg_vld && msg_rdy && !(mrow[mi] < 3 && mcol[mi] < 3);
      if (msg_vld && msg_rdy) mi++;
      if (pld_vld && pld_rdy) pi++;
      prev_stall = och_vld && !och_rdy;
      prev_dat   = och_data;
      next_cycle();
    end
    idle_inputs();
    och_rdy = 1'b1;
    @(negedge clk);
    check("rnd_err_last", 32'(err), 32'(exp_err));
    if (err) err_seen++;
    check("rnd_msgs_done", 32'(mi), 32'(NMSG));
    check("rnd_plds_done", 32'(pi), 32'(pldq.size()));
    check("rnd_flits_done", 32'(ei), 32'(expq.size()));
    check("rnd_err_total", 32'(err_seen), 32'(nbad));
    check("rnd_cnt_final", 32'(pckt_cnt), 32'(1 + ngood));
    check("rnd_vld_final", 32'(och_vld), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
